// File: rtl/wbs_charlie_keys.sv
// Wishbone B4 pipelined slave scanning a 7-pin charlieplexed 42-key matrix with frame-based debounce.
// Ack/data 1 cycle after each request, back-to-back requests accepted, never stalls.
module wbs_charlie_keys #(
    parameter int WB_CLK_HZ = 12000000,
    parameter int SCAN_HZ   = 10000,
    parameter int DEBOUNCE  = 3
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_stall_o,
    output logic        wbs_ack_o,
    input  logic [6:0]  charlie_i,
    output logic [6:0]  charlie_o,
    output logic [6:0]  charlie_oe,
    output logic        irq_o
);
    localparam int CNT_MAX = WB_CLK_HZ / SCAN_HZ;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int HIST_N  = DEBOUNCE - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [6:0]                  sync_a_q, sync_a_d;
    logic [6:0]                  sync_b_q, sync_b_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0]                  col_q, col_d;
    logic [6:0][6:0]             raw_q, raw_d;
    logic [HIST_N-1:0][6:0][6:0] hist_q, hist_d;
    logic [6:0][6:0]             key_q, key_d;
    logic [6:0][6:0]             agree;
    logic                        pending_q, pending_d;
    logic                        irq_en_q, irq_en_d;
    logic [15:0]                 frame_q, frame_d;
    logic                        ack_q, ack_d;
    logic [31:0]                 dat_q, dat_d;
    logic                        irq_q, irq_d;
    logic                        slot_end, frame_end, req;
    logic [31:0]                 rdata;
    logic                        unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:2]};

    // Sample the driven column at the last cycle of its slot; the own-pin bit is meaningless.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (col_q == 3'd6);
        raw_d     = raw_q;
        if (slot_end) begin
            raw_d[col_q]        = ~sync_b_q;
            raw_d[col_q][col_q] = 1'b0;
        end
    end

    // A key may change only when the fresh sample matches every stored history entry.
    always_comb begin
        agree = '1;
        for (int h = 0; h < HIST_N; h++) begin
            agree = agree & ~(hist_q[h] ^ raw_d);
        end
    end

    always_comb begin
        sync_a_d  = charlie_i;
        sync_b_d  = sync_a_q;
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        col_d     = col_q;
        hist_d    = hist_q;
        key_d     = key_q;
        frame_d   = frame_q;
        pending_d = pending_q;
        irq_en_d  = irq_en_q;
        req       = wbs_cyc_i & wbs_stb_i;
        rdata     = '0;

        if (slot_end) begin
            col_d = (col_q == 3'd6) ? 3'd0 : col_q + 3'd1;
        end

        if (frame_end) begin
            hist_d[0] = raw_d;
            for (int h = 1; h < HIST_N; h++) begin
                hist_d[h] = hist_q[h-1];
            end
            key_d   = (agree & raw_d) | (~agree & key_q);
            frame_d = frame_q + 16'd1;
        end

        case (wbs_adr_i)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6:
                rdata = {25'd0, key_q[wbs_adr_i[2:0]]};
            4'd7:    rdata = {30'd0, irq_en_q, pending_q};
            4'd8:    rdata = {16'd0, frame_q};
            default: rdata = '0;
        endcase

        if (req && wbs_we_i && (wbs_adr_i == 4'd7)) begin
            irq_en_d = wbs_dat_i[1];
            if (wbs_dat_i[0]) begin
                pending_d = 1'b0;
            end
        end
        // Evaluated after the clear so a same-cycle key change keeps pending set.
        if (frame_end && (key_d != key_q)) begin
            pending_d = 1'b1;
        end

        ack_d = req;
        dat_d = (req && !wbs_we_i) ? rdata : '0;
        irq_d = pending_q & irq_en_q;
    end

    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            sync_a_q  <= '1;
            sync_b_q  <= '1;
            cnt_q     <= '0;
            col_q     <= '0;
            raw_q     <= '0;
            hist_q    <= '0;
            key_q     <= '0;
            pending_q <= 1'b0;
            irq_en_q  <= 1'b0;
            frame_q   <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_a_q  <= sync_a_d;
            sync_b_q  <= sync_b_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            raw_q     <= raw_d;
            hist_q    <= hist_d;
            key_q     <= key_d;
            pending_q <= pending_d;
            irq_en_q  <= irq_en_d;
            frame_q   <= frame_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
        end
    end

    assign charlie_oe  = 7'b1 << col_q;
    assign charlie_o   = '0;
    assign wbs_stall_o = 1'b0;
    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_wbs_charlie_keys.sv
// Bench for wbs_charlie_keys: directed scenarios plus randomized key/bus traffic against a frame-level model.
module tb_wbs_charlie_keys;
    localparam int CM = 8;
    localparam int FR = 56;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [3:0]  adr, sel;
    logic [31:0] wdat, rdat;
    logic        stall, ack, irq;
    logic [6:0]  pin_i, pin_o, pin_oe;
    logic [6:0]  held [7];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int          tick;
    int          mcol;
    logic        mchg;
    logic [6:0]  m_raw [7];
    logic [6:0]  m_last [7];
    logic [6:0]  m_key [7];
    int          m_streak [7][7];
    logic        m_pend, m_irq_en, m_irq, m_ack;
    logic [15:0] m_frame;
    logic [31:0] m_dat;

    always #5 clk = ~clk;

    wbs_charlie_keys #(.WB_CLK_HZ(80), .SCAN_HZ(10), .DEBOUNCE(DB)) dut (
        .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_sel_i(sel), .wbs_dat_i(wdat),
        .wbs_dat_o(rdat), .wbs_stall_o(stall), .wbs_ack_o(ack),
        .charlie_i(pin_i), .charlie_o(pin_o), .charlie_oe(pin_oe), .irq_o(irq)
    );

    // Matrix: a held key pulls its row pin low while its column pin is driven.
    always_comb begin
        pin_i = 7'h7f;
        for (int c = 0; c < 7; c++)
            if (pin_oe[c])
                for (int r = 0; r < 7; r++)
                    if (held[c][r] && r != c) pin_i[r] = 1'b0;
    end

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a <= 4'd6) return {25'd0, m_key[int'(a)]};
        if (a == 4'd7) return {30'd0, m_irq_en, m_pend};
        if (a == 4'd8) return {16'd0, m_frame};
        return 32'd0;
    endfunction

    // Frame-level model: a key's state follows its sample once DB consecutive frame samples agree.
    always @(posedge clk) begin
        if (rst) begin
            tick = 0; m_pend = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
            m_frame = 16'd0; m_ack = 1'b0; m_dat = 32'd0;
            for (int c = 0; c < 7; c++) begin
                m_raw[c] = '0; m_last[c] = '0; m_key[c] = '0;
                for (int r = 0; r < 7; r++) m_streak[c][r] = DB - 1;
            end
        end else begin
            mcol  = (tick / CM) % 7;
            m_ack = cyc && stb;
            m_dat = (cyc && stb && !we) ? model_read(adr) : 32'd0;
            m_irq = m_pend && m_irq_en;
            if (cyc && stb && we && adr == 4'd7) begin
                m_irq_en = wdat[1];
                if (wdat[0]) m_pend = 1'b0;
            end
            if (tick % CM == CM - 1) begin
                m_raw[mcol] = held[mcol];
                m_raw[mcol][mcol] = 1'b0;
            end
            if (tick % FR == FR - 1) begin
                mchg = 1'b0;
                for (int c = 0; c < 7; c++)
                    for (int r = 0; r < 7; r++) begin
                        if (m_raw[c][r] == m_last[c][r]) begin
                            if (m_streak[c][r] < DB) m_streak[c][r]++;
                        end else m_streak[c][r] = 1;
                        m_last[c][r] = m_raw[c][r];
                        if (m_streak[c][r] >= DB && m_key[c][r] != m_raw[c][r]) begin
                            m_key[c][r] = m_raw[c][r];
                            mchg = 1'b1;
                        end
                    end
                m_frame = m_frame + 16'd1;
                if (mchg) m_pend = 1'b1;
            end
            tick++;
        end
    end

    task automatic wait_frame_end();
        int k = 0;
        do begin @(negedge clk); k++; end while ((tick % FR) != 0 && k < 2 * FR);
        n_chk++;
        if ((tick % FR) != 0) begin n_fail++; $display("FAIL frame_wait: tick %0d not at a frame start", tick); end
    endtask

    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       output logic g_ack, output logic [31:0] g_dat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hf;
        @(negedge clk);
        g_ack = ack; g_dat = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic ga; logic [31:0] gd;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (pin_oe !== 7'h01 || pin_o !== 7'h00) begin n_fail++; $display("FAIL reset_pins: oe=%h o=%h want oe=01 o=00", pin_oe, pin_o); end
        n_chk++; if (ack !== 1'b0 || rdat !== 32'd0 || irq !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_outs: ack=%b dat=%h irq=%b stall=%b want all 0", ack, rdat, irq, stall); end
        rst = 1'b0;
        repeat (7) @(negedge clk);
        n_chk++; if (pin_oe !== 7'h01) begin n_fail++; $display("FAIL col0_hold: oe=%h want 01", pin_oe); end
        @(negedge clk);
        n_chk++; if (pin_oe !== 7'h02) begin n_fail++; $display("FAIL col1_step: oe=%h want 02", pin_oe); end
        for (int a = 0; a < 9; a++) begin
            bus(1'b0, 4'(a), 32'd0, ga, gd);
            n_chk++; if (ga !== 1'b1 || gd !== 32'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_read a=%0d: ack=%b dat=%h stall=%b want 1/0/0", a, ga, gd, stall); end
        end
    endtask

    task automatic test_single_press();
        logic ga; logic [31:0] gd;
        wait_frame_end();
        held[2][5] = 1'b1;
        wait_frame_end(); wait_frame_end();
        bus(1'b0, 4'd2, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h0) begin n_fail++; $display("FAIL press_early: got %h want 0", gd); end
        wait_frame_end();
        bus(1'b0, 4'd2, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h20 || gd !== m_dat) begin n_fail++; $display("FAIL press_visible: got %h want 20 (model %h)", gd, m_dat); end
        bus(1'b0, 4'd7, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h1) begin n_fail++; $display("FAIL press_pending: got %h want 1", gd); end
        for (int c = 0; c < 7; c++) begin
            if (c == 2) continue;
            bus(1'b0, 4'(c), 32'd0, ga, gd);
            n_chk++; if (gd !== 32'h0) begin n_fail++; $display("FAIL press_other col=%0d: got %h want 0", c, gd); end
        end
        held[2][5] = 1'b0;
        repeat (3) wait_frame_end();
        bus(1'b1, 4'd7, 32'h1, ga, gd);
        bus(1'b0, 4'd7, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h0) begin n_fail++; $display("FAIL press_clear: got %h want 0", gd); end
    endtask

    task automatic test_debounce_reject();
        logic ga; logic [31:0] gd;
        for (int i = 0; i < 6; i++) begin
            wait_frame_end();
            held[4][0] = (i % 2 == 0);
            bus(1'b0, 4'd4, 32'd0, ga, gd);
            n_chk++; if (gd !== 32'h0) begin n_fail++; $display("FAIL bounce_state i=%0d: got %h want 0", i, gd); end
            bus(1'b0, 4'd7, 32'd0, ga, gd);
            n_chk++; if (gd !== 32'h0) begin n_fail++; $display("FAIL bounce_pending i=%0d: got %h want 0", i, gd); end
        end
        held[4][0] = 1'b0;
        wait_frame_end();
        bus(1'b0, 4'd4, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h0) begin n_fail++; $display("FAIL bounce_final: got %h want 0", gd); end
    endtask

    task automatic test_irq();
        logic ga; logic [31:0] gd;
        bus(1'b1, 4'd7, 32'h2, ga, gd);
        wait_frame_end();
        held[0][6] = 1'b1;
        repeat (3) wait_frame_end();
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag: irq=%b want 0 in pending-set cycle", irq); end
        @(negedge clk);
        n_chk++; if (irq !== 1'b1 || irq !== m_irq) begin n_fail++; $display("FAIL irq_press: irq=%b want 1", irq); end
        bus(1'b1, 4'd7, 32'h3, ga, gd);
        @(negedge clk);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: irq=%b want 0", irq); end
        bus(1'b0, 4'd7, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h2) begin n_fail++; $display("FAIL irq_en_kept: got %h want 2", gd); end
        held[0][6] = 1'b0;
        repeat (3) wait_frame_end();
        @(negedge clk);
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_release: irq=%b want 1", irq); end
        bus(1'b0, 4'd0, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h0) begin n_fail++; $display("FAIL release_state: got %h want 0", gd); end
        bus(1'b1, 4'd7, 32'h1, ga, gd);
    endtask

    task automatic test_collision();
        logic ga; logic [31:0] gd;
        wait_frame_end();
        held[3][1] = 1'b1;
        repeat (2) wait_frame_end();
        while ((tick % FR) != FR - 1) @(negedge clk);
        bus(1'b1, 4'd7, 32'h1, ga, gd);
        bus(1'b0, 4'd7, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h1 || gd !== m_dat) begin n_fail++; $display("FAIL collision_pending: got %h want 1", gd); end
        bus(1'b0, 4'd3, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h2) begin n_fail++; $display("FAIL collision_state: got %h want 2", gd); end
        held[3][1] = 1'b0;
        repeat (3) wait_frame_end();
        bus(1'b1, 4'd7, 32'h1, ga, gd);
    endtask

    task automatic test_frame_counter();
        logic ga; logic [31:0] gd, g1;
        wait_frame_end();
        bus(1'b0, 4'd8, 32'd0, ga, g1);
        n_chk++; if (g1 !== m_dat || g1[31:16] !== 16'd0) begin n_fail++; $display("FAIL frame_value: got %h want %h", g1, m_dat); end
        wait_frame_end();
        bus(1'b0, 4'd8, 32'd0, ga, gd);
        n_chk++; if (gd[15:0] !== g1[15:0] + 16'd1) begin n_fail++; $display("FAIL frame_step: got %h want %h", gd, g1 + 32'd1); end
        bus(1'b1, 4'd8, 32'h1234, ga, gd);
        bus(1'b0, 4'd8, 32'd0, ga, gd);
        n_chk++; if (gd[15:0] !== g1[15:0] + 16'd1) begin n_fail++; $display("FAIL frame_ro: got %h want %h", gd, g1 + 32'd1); end
    endtask

    task automatic test_back_to_back();
        logic ga; logic [31:0] gd;
        logic [3:0] seq [8];
        seq = '{4'd8, 4'd7, 4'd0, 4'd9, 4'd2, 4'd15, 4'd8, 4'd6};
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, seq[i], 32'd0, ga, gd);
            n_chk++; if (ga !== 1'b1 || gd !== m_dat) begin n_fail++; $display("FAIL b2b i=%0d: ack=%b dat=%h want 1/%h", i, ga, gd, m_dat); end
        end
        @(negedge clk);
        n_chk++; if (ack !== 1'b0 || rdat !== 32'd0) begin n_fail++; $display("FAIL b2b_idle: ack=%b dat=%h want 0/0", ack, rdat); end
    endtask

    task automatic test_random();
        logic ga, w; logic [31:0] gd, d; logic [3:0] a;
        for (int f = 0; f < 25; f++) begin
            wait_frame_end();
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 7; r++)
                    if (r != c && $urandom_range(0, 5) == 0) held[c][r] = ~held[c][r];
            for (int k = 0; k < 4; k++) begin
                a = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
                w = ($urandom_range(0, 3) == 0);
                d = $urandom;
                bus(w, a, d, ga, gd);
                n_chk++; if (ga !== m_ack || gd !== m_dat || irq !== m_irq) begin n_fail++; $display("FAIL random f=%0d a=%0d we=%b: ack=%b dat=%h irq=%b want %b/%h/%b", f, a, w, ga, gd, irq, m_ack, m_dat, m_irq); end
            end
        end
        for (int c = 0; c < 7; c++) held[c] = '0;
        repeat (3) wait_frame_end();
        bus(1'b1, 4'd7, 32'h1, ga, gd);
    endtask

    task automatic test_reset_mid();
        logic ga; logic [31:0] gd;
        wait_frame_end();
        held[5][2] = 1'b1;
        repeat (3) wait_frame_end();
        bus(1'b0, 4'd5, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h4) begin n_fail++; $display("FAIL pre_reset_state: got %h want 4", gd); end
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd5;
        @(negedge clk);
        n_chk++; if (ack !== 1'b0 || rdat !== 32'd0) begin n_fail++; $display("FAIL reset_ack: ack=%b dat=%h want 0/0", ack, rdat); end
        n_chk++; if (pin_oe !== 7'h01 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_scan: oe=%h irq=%b want 01/0", pin_oe, irq); end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        for (int a = 0; a < 9; a++) begin
            bus(1'b0, 4'(a), 32'd0, ga, gd);
            n_chk++; if (ga !== 1'b1 || gd !== 32'd0) begin n_fail++; $display("FAIL post_reset a=%0d: ack=%b dat=%h want 1/0", a, ga, gd); end
        end
        repeat (3) wait_frame_end();
        bus(1'b0, 4'd5, 32'd0, ga, gd);
        n_chk++; if (gd !== 32'h4 || gd !== m_dat) begin n_fail++; $display("FAIL key_return: got %h want 4", gd); end
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 4'd0; sel = 4'hf; wdat = 32'd0;
        for (int c = 0; c < 7; c++) held[c] = '0;
        test_reset();
        test_single_press();
        test_debounce_reject();
        test_irq();
        test_collision();
        test_frame_counter();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
